av2_tile_byte_packer: RTL and testbench

Upstream feeder for the AV2 tile decoder. The block accepts the tile payload as a byte stream from the OBU/tile-group parser and packs it MSB-first into 128-bit words. It buffers those words in a small FIFO and presents them on the `tile_data`/`tile_valid`/`tile_ready` handshake that the tile decoder's entropy stage consumes. It tracks the tile byte count, zero-pads the final partial word and signals completion once every word has been taken.

---
 rtl/av2_tile_byte_packer.sv | 170 +++++++++++++++++
 tb/tb_av2_tile_byte_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/av2_tile_byte_packer.sv
// Packs a tile byte stream MSB-first into 128-bit words and queues them for the tile decoder.
// Optional macro AV2_TILE_PACKER_STATS_EN adds the words_out delivered-word counter port.
module av2_tile_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  tile_size_bytes,
    input  logic         abort,
    input  logic [7:0]   byte_data,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic [127:0] tile_data,
    output logic         tile_valid,
    input  logic         tile_ready,
    output logic         busy,
    output logic         done,
    output logic [31:0]  bytes_left
`ifdef AV2_TILE_PACKER_STATS_EN
    ,
    output logic [31:0]  words_out
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // FILL   | accepting bytes and packing words
    // DRAIN  | all bytes taken, waiting for the FIFO to empty
    // DONE   | one-cycle completion pulse
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [127:0]       pack_q;
    logic [3:0]         pack_cnt_q;
    logic [31:0]        bytes_left_q;
    logic [127:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               fifo_full, fifo_empty;
    logic               accept, last_byte, push, pop, start_ok;
    logic [3:0]         lane;
    logic [127:0]       pack_word;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign start_ok   = start && (state_q == S_IDLE) && !abort;
    assign accept     = byte_valid && byte_ready && !abort;
    assign last_byte  = (bytes_left_q == 32'd1);
    assign push       = accept && ((pack_cnt_q == 4'd15) || last_byte);
    assign pop        = tile_valid && tile_ready && !abort;
    assign lane       = 4'd15 - pack_cnt_q;
    // Lanes below the current one are always zero, so OR-ing in the byte yields the padded word.
    assign pack_word  = pack_q | ({120'd0, byte_data} << {lane, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (tile_size_bytes == 32'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (accept && last_byte) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the final word is taken so DONE follows the last pop directly.
                if (fifo_empty || ((count_q == CNT_W'(1)) && pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        byte_ready = (state_q == S_FILL) && (bytes_left_q != 32'd0) && !fifo_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            bytes_left_q <= '0;
        end else if (abort) begin
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            bytes_left_q <= '0;
        end else if (start_ok) begin
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            bytes_left_q <= tile_size_bytes;
        end else if (accept) begin
            bytes_left_q <= bytes_left_q - 32'd1;
            if (push) begin
                pack_q     <= '0;
                pack_cnt_q <= '0;
            end else begin
                pack_q     <= pack_word;
                pack_cnt_q <= pack_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= pack_word;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign tile_valid = !fifo_empty;
    assign tile_data  = mem_q[rd_ptr_q];
    assign bytes_left = bytes_left_q;

`ifdef AV2_TILE_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (start_ok) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_av2_tile_byte_packer.sv
// Scoreboard bench for av2_tile_byte_packer: expected words queued at stimulus, popped by a monitor.
module tb_av2_tile_byte_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  tile_size_bytes;
    logic         abort;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready;
    logic [127:0] tile_data;
    logic         tile_valid;
    logic         tile_ready;
    logic         busy;
    logic         done;
    logic [31:0]  bytes_left;
`ifdef AV2_TILE_PACKER_STATS_EN
    logic [31:0]  words_out;
`endif

    av2_tile_byte_packer #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .tile_size_bytes (tile_size_bytes),
        .abort           (abort),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .tile_data       (tile_data),
        .tile_valid      (tile_valid),
        .tile_ready      (tile_ready),
        .busy            (busy),
        .done            (done),
        .bytes_left      (bytes_left)
`ifdef AV2_TILE_PACKER_STATS_EN
        ,
        .words_out       (words_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_pop_cyc = -1;
    int done_cyc = -1;
    int done_count = 0;
    int valid_count = 0;
    logic [127:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every delivered word against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tile_valid) valid_count++;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (tile_valid && tile_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got %h expected none", tile_data);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (tile_data !== e) begin
                        errors++;
                        $display("FAIL word_data: got %h expected %h", tile_data, e);
                    end
                end
                last_pop_cyc = cyc;
            end
        end
    end

    function automatic logic [127:0] exp_word(input int n, input int k, input logic [7:0] base);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 16; j++) begin
            if (16 * k + j < n) w[127 - 8 * j -: 8] = base + 8'(16 * k + j);
        end
        return w;
    endfunction

    task automatic expect_tile(input int n, input logic [7:0] base);
        for (int k = 0; k < (n + 15) / 16; k++) exp_q.push_back(exp_word(n, k, base));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] size);
        start = 1'b1;
        tile_size_bytes = size;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int n, input int from, input logic [7:0] base,
                          input int budget, output int upto);
        int i;
        int c;
        logic acc;
        i = from;
        c = 0;
        while (i < n && c < budget) begin
            byte_valid = 1'b1;
            byte_data  = base + 8'(i);
            acc = byte_ready;
            tick();
            if (acc) i++;
            c++;
        end
        byte_valid = 1'b0;
        upto = i;
    endtask

    task automatic wait_done(input int base_cnt, input int budget);
        int c;
        c = 0;
        while (done_count == base_cnt && c < budget) begin
            tick();
            c++;
        end
        chk("done_seen", 128'(done_count > base_cnt), 128'(1));
    endtask

    initial begin
        int got;
        int base_cnt;
        int s_cyc;
        int v0;
        logic [127:0] held;

        rst_n = 1'b0;
        start = 1'b0;
        tile_size_bytes = '0;
        abort = 1'b0;
        byte_data = '0;
        byte_valid = 1'b0;
        tile_ready = 1'b1;
        #2;
        chk("rst_byte_ready", 128'(byte_ready), 128'(0));
        chk("rst_tile_valid", 128'(tile_valid), 128'(0));
        chk("rst_tile_data", tile_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_bytes_left", 128'(bytes_left), 128'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 32-byte tile, free-running consumer
        expect_tile(32, 8'h00);
        base_cnt = done_count;
        pulse_start(32);
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_byte_ready", 128'(byte_ready), 128'(1));
        chk("t1_bytes_left", 128'(bytes_left), 128'(32));
        stream(32, 0, 8'h00, 100, got);
        chk("t1_sent", 128'(got), 128'(32));
        wait_done(base_cnt, 50);
        chk("t1_done_after_pop", 128'(done_cyc), 128'(last_pop_cyc + 1));
        chk("t1_idle", 128'(busy), 128'(0));

        // 19-byte tile with padded tail word
        expect_tile(19, 8'hA0);
        base_cnt = done_count;
        pulse_start(19);
        stream(19, 0, 8'hA0, 100, got);
        chk("t2_bytes_left", 128'(bytes_left), 128'(0));
        wait_done(base_cnt, 50);
        repeat (4) tick();
        chk("t2_done_once", 128'(done_count), 128'(base_cnt + 1));

        // 100-byte tile against a stalled consumer
        tile_ready = 1'b0;
        expect_tile(100, 8'h40);
        base_cnt = done_count;
        pulse_start(100);
        stream(100, 0, 8'h40, 80, got);
        chk("t3_stall_bytes", 128'(got), 128'(64));
        chk("t3_ready_low", 128'(byte_ready), 128'(0));
        held = tile_data;
        chk("t3_head", held, exp_word(100, 0, 8'h40));
        repeat (5) tick();
        chk("t3_stable", tile_data, held);
        chk("t3_valid_held", 128'(tile_valid), 128'(1));
        tile_ready = 1'b1;
        stream(100, got, 8'h40, 300, got);
        chk("t3_sent", 128'(got), 128'(100));
        wait_done(base_cnt, 50);
        chk("t3_drained", 128'(exp_q.size()), 128'(0));

        // zero-length tile
        v0 = valid_count;
        base_cnt = done_count;
        s_cyc = cyc;
        pulse_start(0);
        wait_done(base_cnt, 10);
        chk("t4_done_time", 128'(done_cyc), 128'(s_cyc + 1));
        repeat (3) tick();
        chk("t4_no_valid", 128'(valid_count), 128'(v0));

        // 48-byte tile
        expect_tile(48, 8'hC0);
        base_cnt = done_count;
        pulse_start(48);
        stream(48, 0, 8'hC0, 150, got);
        wait_done(base_cnt, 50);
`ifdef AV2_TILE_PACKER_STATS_EN
        chk("t5_words_out", 128'(words_out), 128'(3));
`endif

        // abort after 20 bytes with one word pending
        tile_ready = 1'b0;
        base_cnt = done_count;
        pulse_start(40);
`ifdef AV2_TILE_PACKER_STATS_EN
        chk("t6_words_out_clr", 128'(words_out), 128'(0));
`endif
        stream(20, 0, 8'h77, 60, got);
        chk("t6_sent", 128'(got), 128'(20));
        chk("t6_pending", 128'(tile_valid), 128'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_idle", 128'(busy), 128'(0));
        chk("t6_valid", 128'(tile_valid), 128'(0));
        chk("t6_bytes_left", 128'(bytes_left), 128'(0));
        repeat (3) tick();
        chk("t6_no_done", 128'(done_count), 128'(base_cnt));
        tile_ready = 1'b1;
        expect_tile(16, 8'h55);
        base_cnt = done_count;
        pulse_start(16);
        stream(16, 0, 8'h55, 60, got);
        wait_done(base_cnt, 50);
        repeat (2) tick();
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
